// File: rtl/abs_diff_err_monitor_pkg.sv
// Shared types, default widths and golden |a-b| function for the abs_diff error monitor.
package absdiff_pkg;

    // Default approximate-circuit geometry and error bound.
    localparam int unsigned N_IN_DEF  = 4;
    localparam int unsigned N_OUT_DEF = 2;
    localparam int unsigned ET_DEF    = 2;

    // Widths derived from the default geometry.
    localparam int unsigned OP_W_DEF  = N_IN_DEF / 2;        // width of each operand a, b
    localparam int unsigned SUM_W_DEF = N_OUT_DEF + N_IN_DEF; // error sum cannot overflow
    localparam int unsigned CNT_W_DEF = N_IN_DEF + 1;         // counts up to 2^N_IN vectors

    // Sweep controller states.
    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DRAIN,
        DONE
    } state_e;

    // Exact |a-b| for a packed input vector: a = low half, b = high half.
    function automatic logic [31:0] abs_diff_exact(input logic [31:0] vec, input int unsigned n_in);
        logic [31:0] mask;
        logic [31:0] a;
        logic [31:0] b;
        mask = (32'd1 << (n_in / 2)) - 32'd1;
        a    = vec & mask;
        b    = (vec >> (n_in / 2)) & mask;
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/abs_diff_err_monitor_if.sv
// Bundle between the error monitor and the approximate circuit / host.
interface abs_diff_err_monitor_if
    import absdiff_pkg::*;
#(
    parameter int unsigned N_IN  = N_IN_DEF,
    parameter int unsigned N_OUT = N_OUT_DEF
);
    logic                  start;
    logic [N_IN-1:0]       vec_o;
    logic [N_OUT-1:0]      approx_i;
    logic                  busy;
    logic                  done;
    logic [N_OUT-1:0]      max_err;
    logic [N_OUT+N_IN-1:0] err_sum;
    logic [N_IN:0]         err_cnt;
    logic                  violation;
    logic [N_IN-1:0]       fail_vec;

    // Monitor side: drives stimulus and statistics.
    modport master (
        input  start, approx_i,
        output vec_o, busy, done, max_err, err_sum, err_cnt, violation, fail_vec
    );

    // Host / approximate-circuit side.
    modport slave (
        output start, approx_i,
        input  vec_o, busy, done, max_err, err_sum, err_cnt, violation, fail_vec
    );
endinterface

// File: rtl/abs_diff_err_monitor_err_calc.sv
// Combinational error of an approximate |a-b| result against the exact value.
module abs_err_calc
    import absdiff_pkg::*;
#(
    parameter int unsigned N_IN  = N_IN_DEF,
    parameter int unsigned N_OUT = N_OUT_DEF
) (
    input  logic [N_IN-1:0]  vec_i,
    input  logic [N_OUT-1:0] approx_i,
    output logic [N_OUT-1:0] err_o
);

    // Exact value zero-extended to N_OUT bits, then unsigned |exact - approx|.
    always_comb begin
        logic [N_OUT-1:0] exact;
        exact = N_OUT'(abs_diff_exact(32'(vec_i), N_IN));
        err_o = (exact >= approx_i) ? (exact - approx_i) : (approx_i - exact);
    end

endmodule

// File: rtl/abs_diff_err_monitor.sv
// Sweeps every input vector through an approximate abs_diff circuit and accumulates
// worst-case error, error sum, mismatch count and the first threshold violation.
module abs_diff_err_monitor
    import absdiff_pkg::*;
#(
    parameter int unsigned N_IN  = N_IN_DEF,
    parameter int unsigned N_OUT = N_OUT_DEF,
    parameter int unsigned ET    = ET_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    abs_diff_err_monitor_if.master bus
);

    localparam int unsigned     SUM_W    = N_OUT + N_IN;
    localparam int unsigned     CNT_W    = N_IN + 1;
    localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

    // Controller
    state_e           state_q, state_d;
    logic [N_IN-1:0]  vec_q, vec_d;
    logic             drain_q, drain_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Pipeline: S1 holds the captured vector, S2 holds its error
    logic             s1_valid_q, s1_valid_d;
    logic [N_IN-1:0]  s1_vec_q, s1_vec_d;
    logic [N_OUT-1:0] s1_approx_q, s1_approx_d;
    logic             s2_valid_q, s2_valid_d;
    logic [N_IN-1:0]  s2_vec_q, s2_vec_d;
    logic [N_OUT-1:0] s2_err_q, s2_err_d;
    logic [N_OUT-1:0] calc_err;

    // Statistics
    logic [N_OUT-1:0] max_err_q, max_err_d;
    logic [SUM_W-1:0] err_sum_q, err_sum_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             viol_q, viol_d;
    logic [N_IN-1:0]  fail_vec_q, fail_vec_d;

    abs_err_calc #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT)
    ) u_err_calc (
        .vec_i    (s1_vec_q),
        .approx_i (s1_approx_q),
        .err_o    (calc_err)
    );

    // Next-state for the sweep FSM, pipeline stages and statistics.
    always_comb begin
        // NOTE: every _d is given its hold/default value first, so no branch can infer a latch.
        state_d     = state_q;
        vec_d       = vec_q;
        drain_d     = drain_q;
        s1_valid_d  = 1'b0;
        s1_vec_d    = s1_vec_q;
        s1_approx_d = s1_approx_q;
        s2_valid_d  = s1_valid_q;
        s2_vec_d    = s1_vec_q;
        s2_err_d    = calc_err;
        max_err_d   = max_err_q;
        err_sum_d   = err_sum_q;
        err_cnt_d   = err_cnt_q;
        viol_d      = viol_q;
        fail_vec_d  = fail_vec_q;

        // Fold the S2 error into the running statistics.
        if (s2_valid_q) begin
            if (s2_err_q > max_err_q) begin
                max_err_d = s2_err_q;
            end
            err_sum_d = err_sum_q + SUM_W'(s2_err_q);
            if (s2_err_q != '0) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
            if ((32'(s2_err_q) > ET) && !viol_q) begin
                viol_d     = 1'b1;
                fail_vec_d = s2_vec_q;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = SWEEP;
                    vec_d      = '0;
                    max_err_d  = '0;
                    err_sum_d  = '0;
                    err_cnt_d  = '0;
                    viol_d     = 1'b0;
                    fail_vec_d = '0;
                end
            end
            SWEEP: begin
                s1_valid_d  = 1'b1;
                s1_vec_d    = vec_q;
                s1_approx_d = bus.approx_i;
                if (vec_q == VEC_LAST) begin
                    // Last vector issued: hold vec_o and let the pipeline empty.
                    state_d = DRAIN;
                    drain_d = 1'b0;
                end else begin
                    vec_d = vec_q + N_IN'(1);
                end
            end
            DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SWEEP) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    // FSM, valid bits and statistics registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            vec_q      <= '0;
            drain_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            max_err_q  <= '0;
            err_sum_q  <= '0;
            err_cnt_q  <= '0;
            viol_q     <= 1'b0;
            fail_vec_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of the others.
            state_q    <= state_d;
            vec_q      <= vec_d;
            drain_q    <= drain_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            max_err_q  <= max_err_d;
            err_sum_q  <= err_sum_d;
            err_cnt_q  <= err_cnt_d;
            viol_q     <= viol_d;
            fail_vec_q <= fail_vec_d;
        end
    end

    // Pipeline payload registers.
    // NOTE: no reset here; the valid bits above gate every use of these values.
    always_ff @(posedge clk) begin
        s1_vec_q    <= s1_vec_d;
        s1_approx_q <= s1_approx_d;
        s2_vec_q    <= s2_vec_d;
        s2_err_q    <= s2_err_d;
    end

    assign bus.vec_o     = vec_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.max_err   = max_err_q;
    assign bus.err_sum   = err_sum_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.violation = viol_q;
    assign bus.fail_vec  = fail_vec_q;

endmodule

// File: tb/tb_abs_diff_err_monitor.sv
// Self-checking bench: two monitors (ET=2 and ET=3) watch the same approximate circuit,
// modelled as a lookup table indexed by the stimulus vector.
module tb_abs_diff_err_monitor;

    logic clk;
    logic rst;
    logic start;
    logic [1:0] approx_tab [16];

    int total = 0;
    int bad   = 0;

    abs_diff_err_monitor_if #(.N_IN(4), .N_OUT(2)) bus_a ();
    abs_diff_err_monitor_if #(.N_IN(4), .N_OUT(2)) bus_b ();

    assign bus_a.start    = start;
    assign bus_b.start    = start;
    assign bus_a.approx_i = approx_tab[bus_a.vec_o];
    assign bus_b.approx_i = approx_tab[bus_b.vec_o];

    abs_diff_err_monitor #(.N_IN(4), .N_OUT(2), .ET(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.master)
    );

    abs_diff_err_monitor #(.N_IN(4), .N_OUT(2), .ET(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every output of one monitor packed together; zero means the reset state.
    function automatic logic [23:0] all_outputs(input bit sel);
        if (sel)
            return {bus_b.busy, bus_b.done, bus_b.vec_o, bus_b.max_err, bus_b.err_sum,
                    bus_b.err_cnt, bus_b.violation, bus_b.fail_vec};
        return {bus_a.busy, bus_a.done, bus_a.vec_o, bus_a.max_err, bus_a.err_sum,
                bus_a.err_cnt, bus_a.violation, bus_a.fail_vec};
    endfunction

    task automatic fill_exact();
        for (int v = 0; v < 16; v++) begin
            int a, b;
            a = v % 4;
            b = v / 4;
            approx_tab[v] = 2'((a > b) ? a - b : b - a);
        end
    endtask

    task automatic fill_zero();
        for (int v = 0; v < 16; v++) approx_tab[v] = 2'd0;
    endtask

    task automatic fill_random();
        for (int v = 0; v < 16; v++) approx_tab[v] = 2'($urandom_range(0, 3));
    endtask

    // Reference statistics from the table: plain arithmetic over all 16 (a, b) pairs.
    task automatic model(input int et, output int mx, output int sm, output int cnt,
                         output int viol, output int fv);
        mx = 0; sm = 0; cnt = 0; viol = 0; fv = 0;
        for (int v = 0; v < 16; v++) begin
            int a, b, ex, ap, e;
            a  = v % 4;
            b  = v / 4;
            ex = (a > b) ? a - b : b - a;
            ap = int'(approx_tab[v]);
            e  = (ex > ap) ? ex - ap : ap - ex;
            if (e > mx) mx = e;
            sm += e;
            if (e != 0) cnt++;
            if (e > et && viol == 0) begin
                viol = 1;
                fv   = v;
            end
        end
    endtask

    // One full sweep: pulses start, checks busy/done/vec_o timing every cycle,
    // optionally re-pulses start mid-sweep (r1, r2) and in the done cycle, waits
    // idle_wait idle cycles with a scrambled table, then checks statistics.
    task automatic run_sweep(input string name, input int r1, input int r2,
                             input bit start_in_done, input int idle_wait);
        int e_mx[2], e_sm[2], e_cnt[2], e_viol[2], e_fv[2];
        int exp_vec;
        logic exp_busy, exp_done;
        logic [31:0] g_mx, g_sm, g_cnt, g_viol, g_fv;

        model(2, e_mx[0], e_sm[0], e_cnt[0], e_viol[0], e_fv[0]);
        model(3, e_mx[1], e_sm[1], e_cnt[1], e_viol[1], e_fv[1]);

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            exp_vec  = (cyc <= 16) ? cyc - 1 : 15;
            exp_busy = (cyc < 19);
            exp_done = (cyc == 19);
            total += 4;
            if (bus_a.busy !== exp_busy) begin
                bad++;
                $display("FAIL %s busy_a cyc=%0d got=%b exp=%b", name, cyc, bus_a.busy, exp_busy);
            end
            if (bus_b.busy !== exp_busy) begin
                bad++;
                $display("FAIL %s busy_b cyc=%0d got=%b exp=%b", name, cyc, bus_b.busy, exp_busy);
            end
            if (bus_a.done !== exp_done) begin
                bad++;
                $display("FAIL %s done_a cyc=%0d got=%b exp=%b", name, cyc, bus_a.done, exp_done);
            end
            if (bus_b.done !== exp_done) begin
                bad++;
                $display("FAIL %s done_b cyc=%0d got=%b exp=%b", name, cyc, bus_b.done, exp_done);
            end
            if (cyc <= 18) begin
                total++;
                if (bus_a.vec_o !== 4'(exp_vec)) begin
                    bad++;
                    $display("FAIL %s vec_o cyc=%0d got=%0d exp=%0d", name, cyc, bus_a.vec_o, exp_vec);
                end
            end
            start = (cyc == r1) || (cyc == r2) || (start_in_done && cyc == 19);
            @(posedge clk); #1;
        end
        start = 1'b0;

        // Statistics must hold in idle whatever the approximate circuit now does.
        for (int i = 0; i < idle_wait; i++) begin
            fill_random();
            @(posedge clk); #1;
        end

        for (int d = 0; d < 2; d++) begin
            g_mx   = d ? 32'(bus_b.max_err)   : 32'(bus_a.max_err);
            g_sm   = d ? 32'(bus_b.err_sum)   : 32'(bus_a.err_sum);
            g_cnt  = d ? 32'(bus_b.err_cnt)   : 32'(bus_a.err_cnt);
            g_viol = d ? 32'(bus_b.violation) : 32'(bus_a.violation);
            g_fv   = d ? 32'(bus_b.fail_vec)  : 32'(bus_a.fail_vec);
            total += 5;
            if (g_mx !== e_mx[d]) begin
                bad++;
                $display("FAIL %s max_err dut=%0d got=%0d exp=%0d", name, d, g_mx, e_mx[d]);
            end
            if (g_sm !== e_sm[d]) begin
                bad++;
                $display("FAIL %s err_sum dut=%0d got=%0d exp=%0d", name, d, g_sm, e_sm[d]);
            end
            if (g_cnt !== e_cnt[d]) begin
                bad++;
                $display("FAIL %s err_cnt dut=%0d got=%0d exp=%0d", name, d, g_cnt, e_cnt[d]);
            end
            if (g_viol !== e_viol[d]) begin
                bad++;
                $display("FAIL %s violation dut=%0d got=%0d exp=%0d", name, d, g_viol, e_viol[d]);
            end
            if (g_fv !== e_fv[d]) begin
                bad++;
                $display("FAIL %s fail_vec dut=%0d got=%0d exp=%0d", name, d, g_fv, e_fv[d]);
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        fill_zero();
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            total++;
            if (all_outputs(d[0]) !== 24'h0) begin
                bad++;
                $display("FAIL reset outputs dut=%0d got=%h exp=0", d, all_outputs(d[0]));
            end
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            total++;
            if (all_outputs(d[0]) !== 24'h0) begin
                bad++;
                $display("FAIL idle_after_reset dut=%0d got=%h exp=0", d, all_outputs(d[0]));
            end
        end
    endtask

    task automatic test_exact();
        fill_exact();
        run_sweep("exact", 0, 0, 1'b0, 0);
    endtask

    task automatic test_stuck_zero();
        fill_zero();
        run_sweep("stuck0", 0, 0, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            fill_random();
            run_sweep("random", 0, 0, 1'b0, 4);
        end
    endtask

    task automatic test_restart_ignored();
        fill_zero();
        run_sweep("restart", 3, 10, 1'b1, 0);
    endtask

    task automatic test_midsweep_reset();
        fill_zero();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc < 8; cyc++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            total++;
            if (all_outputs(d[0]) !== 24'h0) begin
                bad++;
                $display("FAIL midsweep_rst dut=%0d got=%h exp=0", d, all_outputs(d[0]));
            end
        end
        run_sweep("after_rst", 0, 0, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        fill_zero();
        run_sweep("b2b_first", 0, 0, 1'b0, 0);
        fill_exact();
        run_sweep("b2b_second", 0, 0, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_exact();
        test_stuck_zero();
        test_random();
        test_restart_ignored();
        test_midsweep_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
